batch_scheduler: RTL and testbench
==================================

Name: batch_scheduler

Overview:
- Parametrised successor of the RF-to-TWN glue stage. Sits between the RF data converter I/Q AXI-Stream outputs, the TWN classifier core and the host-bound predictions AXI-Stream.
- Generalises sample lanes per beat, class count and output bus width.
- Adds a prediction FIFO with real backpressure, packetises BATCH predictions per TLAST frame, and exposes saturating drop and I/Q-mismatch counters.

Parameters:
- CLASSES, 4, number of 16-bit class scores per prediction.
- SPB, 2, 16-bit samples per I (and per Q) input beat; input width is 16*SPB.
- OUT_W, 512, predictions TDATA width; must be at least 16*CLASSES.
- FIFO_DEPTH, 8, prediction FIFO entries; power of two, at least 2.
- BATCH, 4, predictions per output packet; at least 1.

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- i_in_TDATA  in  16*SPB  I samples; sample k occupies bits [16k+15:16k]
- i_in_TVALID  in  1  I beat valid
- i_in_TREADY  out  1  I ready
- q_in_TDATA  in  16*SPB  Q samples, same layout as I
- q_in_TVALID  in  1  Q beat valid
- q_in_TREADY  out  1  Q ready
- twn_vld_in  out  1  TWN input valid
- twn_data_in  out  2*SPB x 16  interleaved I/Q lanes to TWN
- twn_vld_out  in  1  TWN prediction valid (single-cycle pulse)
- twn_data_out  in  CLASSES x 16  TWN class scores
- predictions_TDATA  out  OUT_W  prediction beat to host
- predictions_TVALID  out  1  output valid
- predictions_TLAST  out  1  last beat of a BATCH packet
- predictions_TREADY  in  1  host ready
- drop_count  out  16  saturating count of predictions dropped on a full FIFO
- mismatch_count  out  16  saturating count of cycles where exactly one of i_in_TVALID / q_in_TVALID is high

Behaviour:
- Reset (async assert, sync release): every register and output is 0, including TREADYs, twn_vld_in, twn_data_in, TVALID, TLAST, TDATA, both counters, FIFO pointers and the batch counter.
- Input side:
  - i_in_TREADY and q_in_TREADY = 1 whenever rstn is high. The ADC stream is never stalled.
  - Both TVALID high: both beats are registered, and twn_vld_in = 1 on the next cycle (latency 1).
  - Otherwise twn_vld_in = 0 next cycle and twn_data_in is cleared to 0.
  - Exactly one TVALID high: that beat is discarded and mismatch_count increments.
- Lane mapping, for s in 0..SPB-1:
  - twn_data_in[2s] = Q sample SPB-1-s
  - twn_data_in[2s+1] = I sample SPB-1-s
  - For SPB=2 this gives [0]=Q[31:16], [1]=I[31:16], [2]=Q[15:0], [3]=I[15:0].
- Prediction FIFO:
  - A twn_vld_out pulse pushes twn_data_out.
  - Pop occurs when predictions_TVALID and predictions_TREADY are both high.
  - On push while full: if a pop happens in the same cycle, the push is accepted. If no pop, the push is dropped and drop_count increments.
  - Both counters saturate at 16'hFFFF.
- Output:
  - First-word fall-through with a registered output: a push into an empty FIFO raises TVALID on the next cycle.
  - TDATA[16i+15:16i] = class i; bits [OUT_W-1:16*CLASSES] are 0.
  - TDATA, TVALID and TLAST stay stable while TVALID=1 and TREADY=0.
  - When TVALID=0, TDATA is 0.
  - Back-to-back beats are sustained at 1 per cycle while TREADY stays high.
- Batch counter, range 0..BATCH-1:
  - TLAST = 1 exactly when the batch counter equals BATCH-1 (for BATCH=1, every beat).
  - The counter increments on each pop and wraps to 0 after the TLAST beat.
  - Dropped predictions do not advance the batch counter.
- Reset mid-packet: the FIFO is flushed and the batch counter returns to 0. The next packet restarts at beat 0.

Test Plan:
- Both TVALID high for 3 cycles with I=0x1111_2222, Q=0x3333_4444 -> twn_vld_in high for 3 cycles starting 1 cycle later; lanes read 0x3333, 0x1111, 0x4444, 0x2222.
- i_in_TVALID high, q_in_TVALID low for 5 cycles -> twn_vld_in stays 0; mismatch_count = 5.
- TREADY=1, BATCH=4, 8 twn_vld_out pulses with scores 1..8 in class 0 -> 8 output beats; TLAST on beats 4 and 8; TDATA[511:64] = 0.
- TREADY=0, FIFO_DEPTH=8, 10 pushes -> TVALID holds with first data stable; drop_count = 2. After TREADY rises, exactly 8 beats drain in order.
- FIFO full, push and pop in the same cycle -> push accepted, drop_count unchanged, occupancy stays 8.
- rstn pulsed low after beat 2 of a packet -> all outputs 0 immediately; after release, the next 4 predictions give TLAST on the 4th beat.

Source files
------------

// File: rtl/batch_scheduler.sv
// batch_scheduler: I/Q lane packer feeding the TWN core, plus a prediction FIFO
// that packetises BATCH predictions per TLAST frame with drop/mismatch counters.
module batch_scheduler #(
  parameter int CLASSES    = 4,
  parameter int SPB        = 2,
  parameter int OUT_W      = 512,
  parameter int FIFO_DEPTH = 8,
  parameter int BATCH      = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [16*SPB-1:0]             i_in_TDATA,
  input  logic                          i_in_TVALID,
  output logic                          i_in_TREADY,
  input  logic [16*SPB-1:0]             q_in_TDATA,
  input  logic                          q_in_TVALID,
  output logic                          q_in_TREADY,
  output logic                          twn_vld_in,
  output logic [2*SPB-1:0][15:0]        twn_data_in,
  input  logic                          twn_vld_out,
  input  logic [CLASSES-1:0][15:0]      twn_data_out,
  output logic [OUT_W-1:0]              predictions_TDATA,
  output logic                          predictions_TVALID,
  output logic                          predictions_TLAST,
  input  logic                          predictions_TREADY,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   mismatch_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = BATCH > 1 ? $clog2(BATCH) : 1;
  localparam int DW = 16 * CLASSES;

  logic [2*SPB-1:0][15:0] lanes;
  logic                   both, mism;
  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [BW-1:0]          bcnt;
  logic                   full, pop, push, drop;

  // The ADC stream is never stalled, so ready simply follows reset.
  assign i_in_TREADY = rstn;
  assign q_in_TREADY = rstn;
  assign both = i_in_TVALID & q_in_TVALID;
  assign mism = i_in_TVALID ^ q_in_TVALID;

  // Highest-index sample goes first, Q before I in each pair.
  always_comb begin
    lanes = '0;
    for (int s = 0; s < SPB; s++) begin
      lanes[2*s]   = q_in_TDATA[16*(SPB-1-s) +: 16];
      lanes[2*s+1] = i_in_TDATA[16*(SPB-1-s) +: 16];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      twn_vld_in     <= 1'b0;
      twn_data_in    <= '0;
      mismatch_count <= '0;
    end else begin
      twn_vld_in  <= both;
      twn_data_in <= both ? lanes : '0;
      if (mism && mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
    end
  end

  assign full               = count == (AW+1)'(FIFO_DEPTH);
  assign predictions_TVALID = count != '0;
  assign pop                = predictions_TVALID & predictions_TREADY;
  // A pop in the same cycle frees the slot the incoming push will occupy.
  assign push               = twn_vld_out & (~full | pop);
  assign drop               = twn_vld_out & full & ~pop;
  assign predictions_TDATA  = predictions_TVALID ? OUT_W'(mem[rd_ptr]) : '0;
  assign predictions_TLAST  = predictions_TVALID && bcnt == BW'(BATCH - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bcnt       <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= twn_data_out;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        bcnt   <= bcnt == BW'(BATCH - 1) ? '0 : bcnt + BW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_batch_scheduler.sv
// tb_batch_scheduler: vector table for the input stage, scoreboard queue for the
// prediction FIFO / packetiser, and hand-written stall, full-FIFO and reset sequences.
module tb_batch_scheduler;
  logic               clk = 0, rstn = 0;
  logic [31:0]        i_in_TDATA = '0, q_in_TDATA = '0;
  logic               i_in_TVALID = 0, q_in_TVALID = 0, i_in_TREADY, q_in_TREADY;
  logic               twn_vld_in, twn_vld_out = 0;
  logic [3:0][15:0]   twn_data_in, twn_data_out = '0;
  logic [511:0]       predictions_TDATA;
  logic               predictions_TVALID, predictions_TLAST, predictions_TREADY = 0;
  logic [15:0]        drop_count, mismatch_count;

  int checks = 0, errors = 0;
  int bidx = 0, beats = 0, tlasts = 0, exp_drops = 0, mm = 0;
  logic [63:0] exp_q [$];

  batch_scheduler dut (
    .clk(clk), .rstn(rstn),
    .i_in_TDATA(i_in_TDATA), .i_in_TVALID(i_in_TVALID), .i_in_TREADY(i_in_TREADY),
    .q_in_TDATA(q_in_TDATA), .q_in_TVALID(q_in_TVALID), .q_in_TREADY(q_in_TREADY),
    .twn_vld_in(twn_vld_in), .twn_data_in(twn_data_in),
    .twn_vld_out(twn_vld_out), .twn_data_out(twn_data_out),
    .predictions_TDATA(predictions_TDATA), .predictions_TVALID(predictions_TVALID),
    .predictions_TLAST(predictions_TLAST), .predictions_TREADY(predictions_TREADY),
    .drop_count(drop_count), .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Acceptance model: the queue holds exactly what the FIFO holds, and a full
  // FIFO still accepts when its head is leaving this cycle.
  task automatic push(input logic [63:0] d);
    twn_data_out = d;
    twn_vld_out  = 1;
    if (exp_q.size() < 8 || predictions_TREADY) exp_q.push_back(d);
    else exp_drops++;
    step;
    twn_vld_out = 0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rstn && predictions_TVALID && predictions_TREADY) begin
      if (exp_q.size() == 0) chk("unexpected_beat", predictions_TDATA, 0);
      else chk("beat_data", predictions_TDATA[63:0], exp_q.pop_front());
      chk("beat_upper_zero", predictions_TDATA[511:64], 0);
      chk("beat_tlast", predictions_TLAST, bidx == 3);
      if (predictions_TLAST) tlasts++;
      bidx = (bidx + 1) % 4;
      beats++;
    end
  end

  typedef struct {
    logic        iv, qv;
    logic [31:0] i, q;
    logic        vld;
    logic [63:0] lanes;
  } vec_t;
  vec_t vt [11];

  initial begin
    for (int k = 0; k < 3; k++) vt[k] = '{1, 1, 32'h1111_2222, 32'h3333_4444, 1, 64'h2222_4444_1111_3333};
    for (int k = 3; k < 8; k++) vt[k] = '{1, 0, 32'h1111_2222, 32'h3333_4444, 0, 64'h0};
    vt[8]  = '{0, 1, 32'h5555_6666, 32'h7777_8888, 0, 64'h0};
    vt[9]  = '{1, 1, 32'hABCD_0123, 32'h4567_89EF, 1, 64'h0123_89EF_ABCD_4567};
    vt[10] = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h0};

    step;
    step;
    chk("rst_i_ready", i_in_TREADY, 0);
    chk("rst_q_ready", q_in_TREADY, 0);
    chk("rst_twn_vld", twn_vld_in, 0);
    chk("rst_tvalid", predictions_TVALID, 0);
    chk("rst_tdata", predictions_TDATA, 0);
    chk("rst_tlast", predictions_TLAST, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_mismatch", mismatch_count, 0);
    rstn = 1;
    step;
    chk("ready_after_rst", {i_in_TREADY, q_in_TREADY}, 2'b11);

    for (int k = 0; k < 11; k++) begin
      i_in_TVALID = vt[k].iv;
      q_in_TVALID = vt[k].qv;
      i_in_TDATA  = vt[k].i;
      q_in_TDATA  = vt[k].q;
      mm += int'(vt[k].iv ^ vt[k].qv);
      step;
      chk($sformatf("vec%0d_vld", k), twn_vld_in, vt[k].vld);
      chk($sformatf("vec%0d_lanes", k), twn_data_in, vt[k].lanes);
      chk($sformatf("vec%0d_mismatch", k), mismatch_count, mm);
    end
    i_in_TVALID = 0;
    q_in_TVALID = 0;

    // Streaming with host always ready: eight beats, TLAST on 4 and 8.
    predictions_TREADY = 1;
    beats = 0;
    tlasts = 0;
    for (int k = 1; k <= 8; k++) push(64'(k));
    wait_empty(2);
    chk("a_beats", beats, 8);
    chk("a_tlasts", tlasts, 2);
    step;
    chk("idle_tvalid", predictions_TVALID, 0);
    chk("idle_tdata", predictions_TDATA, 0);

    // Host stalled: ten pushes into eight slots, head held stable.
    predictions_TREADY = 0;
    for (int k = 1; k <= 10; k++) push(64'h10 + 64'(k));
    for (int k = 0; k < 3; k++) begin
      chk("stall_tvalid", predictions_TVALID, 1);
      chk("stall_tdata", predictions_TDATA, 512'h11);
      chk("stall_tlast", predictions_TLAST, bidx == 3);
      step;
    end
    chk("stall_drops", drop_count, exp_drops);
    chk("stall_drops_const", drop_count, 2);
    predictions_TREADY = 1;
    push(64'h99);
    predictions_TREADY = 0;
    chk("fullpop_drops", drop_count, 2);
    chk("fullpop_head", predictions_TDATA, 512'h12);
    push(64'hAA);
    chk("still_full_drop", drop_count, exp_drops);
    beats = 0;
    predictions_TREADY = 1;
    wait_empty(12);
    chk("b_beats", beats, 8);
    step;
    chk("b_tvalid_end", predictions_TVALID, 0);

    // Reset two beats into a packet.
    for (int k = 0; k < 3; k++) push(64'h200 + 64'(k));
    wait_empty(3);
    chk("c_at_pkt_start", bidx, 0);
    push(64'h300);
    push(64'h301);
    wait_empty(3);
    predictions_TREADY = 0;
    push(64'h302);
    push(64'h303);
    i_in_TVALID = 1;
    q_in_TVALID = 1;
    #2 rstn = 0;
    #1;
    chk("mid_rst_tvalid", predictions_TVALID, 0);
    chk("mid_rst_tdata", predictions_TDATA, 0);
    chk("mid_rst_tlast", predictions_TLAST, 0);
    chk("mid_rst_twn", {twn_vld_in, twn_data_in}, 0);
    chk("mid_rst_ready", {i_in_TREADY, q_in_TREADY}, 0);
    chk("mid_rst_cnt", {drop_count, mismatch_count}, 0);
    exp_q.delete();
    bidx = 0;
    exp_drops = 0;
    i_in_TVALID = 0;
    q_in_TVALID = 0;
    step;
    rstn = 1;
    step;
    chk("post_rst_tvalid", predictions_TVALID, 0);
    predictions_TREADY = 1;
    beats = 0;
    tlasts = 0;
    for (int k = 0; k < 4; k++) push(64'h400 + 64'(k));
    wait_empty(3);
    chk("c_beats", beats, 4);
    chk("c_tlasts", tlasts, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
